ex_mdu: RTL

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_pkg.sv | 34 +++
 rtl/ex_mdu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg -- shared encodings for the M-extension multiply/divide unit.
//   INST_TYPE_R_M : major opcode of R-type M-extension instructions
//   F3_*          : funct3 op select codes (RV32M)
//   mdu_state_t   : FSM state encoding
//   f3_rs1_signed / f3_rs2_signed : which operands are treated as signed
package ex_mdu_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  // MUL low half is sign-agnostic, so it runs on raw (unsigned) operands.
  function automatic logic f3_rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// ex_mdu -- iterative RV32M multiply/divide unit.
// One shared (XLEN+2)-bit adder/subtractor serves both the shift-add
// multiplier and the restoring divider; one result bit per CALC cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start_i, funct3_i     request + op select (accepted only in IDLE, no flush)
//   rs1_data_i/rs2_data_i operands (dividend/multiplicand, divisor/multiplier)
//   rd_addr_i             destination register
//   flush_i               abort the current operation
//   busy_o, hold_o        occupied / pipeline stall request
//   valid_o, rd_wr_en_o   one-cycle result strobe (DONE state)
//   result_o, rd_addr_o   result and destination, held outside DONE
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wr_en_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q, rd_addr_q;
  logic [XLEN-1:0] acc_q, lo_q, b_q, result_q;
  logic            neg_q, rneg_q;

  // ---------------- request decode ----------------
  logic            accept, s1, s2, div_zero, div_ovf, quick;
  logic [XLEN-1:0] mag1, mag2, quick_res;

  assign accept   = (state_q == S_IDLE) && start_i && !flush_i;
  assign s1       = f3_rs1_signed(funct3_i) && rs1_data_i[XLEN-1];
  assign s2       = f3_rs2_signed(funct3_i) && rs2_data_i[XLEN-1];
  assign mag1     = s1 ? -rs1_data_i : rs1_data_i;
  assign mag2     = s2 ? -rs2_data_i : rs2_data_i;
  assign div_zero = (rs2_data_i == '0);
  assign div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                    (rs1_data_i == SMIN) && (rs2_data_i == '1);
  // Divide-by-zero and signed overflow have closed-form results: skip CALC.
  assign quick    = funct3_i[2] && (div_zero || div_ovf);

  always_comb begin
    quick_res = '0;
    if (div_zero) quick_res = funct3_i[1] ? rs1_data_i : '1;
    else          quick_res = funct3_i[1] ? '0 : rs1_data_i;
  end

  // ---------------- shared adder/subtractor ----------------
  logic              is_div, ge, last;
  logic [XLEN:0]     x_op, madd;
  logic [XLEN+1:0]   sum;
  logic [XLEN-1:0]   acc_n, lo_n;

  assign is_div = op_q[2];
  // Divide: shifted remainder in, subtract divisor. Multiply: high half + multiplicand.
  assign x_op   = is_div ? {acc_q, lo_q[XLEN-1]} : {1'b0, acc_q};
  assign sum    = {1'b0, x_op} + (is_div ? ~{2'b00, b_q} : {2'b00, b_q})
                  + {{(XLEN+1){1'b0}}, is_div};
  assign ge     = ~sum[XLEN+1];
  assign madd   = lo_q[0] ? sum[XLEN:0] : {1'b0, acc_q};

  always_comb begin
    if (is_div) begin
      acc_n = ge ? sum[XLEN-1:0] : x_op[XLEN-1:0];
      lo_n  = {lo_q[XLEN-2:0], ge};
    end else begin
      acc_n = madd[XLEN:1];
      lo_n  = {madd[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------- result formation ----------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin;

  generate
    if (FAST_MUL) begin : g_fast
      assign prod = is_div ? {acc_n, lo_n} : ((2*XLEN)'(b_q) * (2*XLEN)'(lo_q));
    end else begin : g_iter
      assign prod = {acc_n, lo_n};
    end
  endgenerate

  assign prod_s = neg_q  ? -prod  : prod;
  assign quo_s  = neg_q  ? -lo_n  : lo_n;
  assign rem_s  = rneg_q ? -acc_n : acc_n;

  always_comb begin
    fin = '0;
    case (op_q)
      F3_MUL:                     fin = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:                   fin = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:            fin = quo_s;
      default:                    fin = rem_s;
    endcase
  end

  assign last = (cnt_q == CW'(XLEN-1)) || (FAST_MUL && !is_div);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy_o     = (state_q != S_IDLE);
    hold_o     = (busy_o && (state_q != S_DONE)) || ((state_q == S_IDLE) && start_i);
    valid_o    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = quick ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush_i)   state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_o = !flush_i;
      end
      default: state_d = S_IDLE;
    endcase
    rd_wr_en_o = valid_o;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rd_addr_q <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
    end else if (accept) begin
      op_q   <= funct3_i;
      rd_q   <= rd_addr_i;
      cnt_q  <= '0;
      acc_q  <= '0;
      neg_q  <= s1 ^ s2;
      rneg_q <= s1;
      // lo_q is the operand consumed bit by bit: dividend or multiplier.
      lo_q   <= funct3_i[2] ? mag1 : mag2;
      b_q    <= funct3_i[2] ? mag2 : mag1;
      if (quick) begin
        result_q  <= quick_res;
        rd_addr_q <= rd_addr_i;
      end
    end else if (state_q == S_CALC) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
      if (last && !flush_i) begin
        result_q  <= fin;
        rd_addr_q <= rd_q;
      end
    end
  end

  assign result_o  = result_q;
  assign rd_addr_o = rd_addr_q;

endmodule
